counter2bit: RTL and testbench

Registered 2-bit up/down counter: on every rising clock edge the count steps by one in the direction selected by `up_down`, wrapping modulo 4. It is a standalone leaf block with no enable or load. Its value is exposed directly on `count` for downstream logic and for the bench's scoreboard, which predicts the value cycle by cycle.

---
 rtl/counter2bit.sv | 12 +
 tb/tb_counter2bit.sv | 74 +++++++
 2 files changed

// File: rtl/counter2bit.sv
// counter2bit: registered modulo-2^WIDTH up/down counter with synchronous reset
module counter2bit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    count <= reset ? '0 : up_down ? count + WIDTH'(1) : count - WIDTH'(1);
endmodule

// File: tb/tb_counter2bit.sv
// tb_counter2bit: directed table, hand-written mid-reset sequence, and random run against a scoreboard
module tb_counter2bit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_down = 1'b0;
  logic [1:0] count;
  int         n_cmp = 0;
  int         n_err = 0;

  counter2bit #(.WIDTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .up_down(up_down),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       ud;
    logic [1:0] exp;
  } vec_t;

  // Each row is applied for one edge; expectations chain from the previous row.
  vec_t tbl [22] = '{
    '{1'b1, 1'b0, 2'd0}, '{1'b1, 1'b1, 2'd0},
    '{1'b0, 1'b1, 2'd1}, '{1'b0, 1'b1, 2'd2}, '{1'b0, 1'b1, 2'd3},
    '{1'b0, 1'b1, 2'd0}, '{1'b0, 1'b1, 2'd1}, '{1'b0, 1'b1, 2'd2},
    '{1'b1, 1'b0, 2'd0},
    '{1'b0, 1'b0, 2'd3}, '{1'b0, 1'b0, 2'd2}, '{1'b0, 1'b0, 2'd1},
    '{1'b0, 1'b0, 2'd0}, '{1'b0, 1'b0, 2'd3}, '{1'b0, 1'b0, 2'd2},
    '{1'b1, 1'b1, 2'd0},
    '{1'b0, 1'b1, 2'd1}, '{1'b0, 1'b1, 2'd2}, '{1'b0, 1'b0, 2'd1},
    '{1'b0, 1'b0, 2'd0}, '{1'b0, 1'b0, 2'd3}, '{1'b0, 1'b1, 2'd0}
  };

  task automatic step(input logic r, input logic ud, input logic [1:0] exp, input string name);
    @(negedge clk);
    reset = r;
    up_down = ud;
    @(posedge clk);
    #1;
    n_cmp++;
    if (count !== exp) begin
      n_err++;
      $display("FAIL %s: count=%b expected=%b", name, count, exp);
    end
  endtask

  initial begin
    logic [1:0] model;
    logic       r;
    logic       ud;
    for (int i = 0; i < 22; i++)
      step(tbl[i].r, tbl[i].ud, tbl[i].exp, $sformatf("table[%0d]", i));
    step(1'b1, 1'b0, 2'd0, "mid_reset_init");
    step(1'b0, 1'b1, 2'd1, "mid_reset_up1");
    step(1'b0, 1'b1, 2'd2, "mid_reset_up2");
    step(1'b0, 1'b1, 2'd3, "mid_reset_up3");
    step(1'b1, 1'b1, 2'd0, "mid_reset_pulse");
    step(1'b0, 1'b1, 2'd1, "mid_reset_after1");
    step(1'b0, 1'b1, 2'd2, "mid_reset_after2");
    model = 2'd2;
    for (int i = 0; i < 240; i++) begin
      r = ($urandom_range(15) == 0);
      ud = 1'($urandom_range(1));
      model = r ? 2'd0 : ud ? model + 2'd1 : model - 2'd1;
      step(r, ud, model, $sformatf("random[%0d]", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
